axi_cache_master: RTL
=====================

// Module: axi_cache_master
// PURPOSE
//  AXI initiator for the DRAM-cache datapath: takes one line-sized read or write request from the
//  cache controller, drives AR/R or AW/W/B to the tag+data memory slave, returns the completion.
//  One transaction outstanding, single-beat (576b read = 64b tag + 512b data; 512b write).
// PARAMETERS
//  ADDR_W 64 address width | DATA_W 512 line data width | TAG_S 64 tag word width on R
//  ID_W 16 id width | ID 1 value driven on arid/awid/wid, expected on rid/bid
//  TIMEOUT_CYC 1024 watchdog limit in cycles (used only with AXI_MASTER_TIMEOUT_EN)
// PORTS
//  clk in 1 clock | rst in 1 sync active-high reset
//  req_valid_i in 1 / req_ready_o out 1 request handshake | req_write_i in 1 1=write 0=read
//  req_addr_i in ADDR_W line address | req_wdata_i in DATA_W write line
//  resp_valid_o out 1 / resp_ready_i in 1 completion handshake | resp_write_o out 1 type of completion
//  resp_rdata_o out TAG_S+DATA_W {tag,data} for reads, 0 for writes | resp_err_o out 1 id mismatch/timeout
//  arid_o out ID_W, araddr_o out ADDR_W, arvalid_o out 1, arready_i in 1
//  rid_i in ID_W, rdata_i in TAG_S+DATA_W, rvalid_i in 1, rready_o out 1
//  awid_o out ID_W, awaddr_o out ADDR_W, awvalid_o out 1, awready_i in 1
//  wid_o out ID_W, wdata_o out DATA_W, wvalid_o out 1, wready_i in 1
//  bid_i in ID_W, bvalid_i in 1, bready_o out 1
// BEHAVIOUR
//  One clock (clk); reset synchronous active-high (rst); all outputs registered or FSM-decoded.
//  Reset: state IDLE, req_ready_o=1, all *valid_o/rready_o/bready_o/resp_*=0, addr/data regs 0.
//  FSM: IDLE -> AR -> R -> RESP (read); IDLE -> AWW -> B -> RESP (write); RESP -> IDLE.
//  IDLE: req_ready_o=1; on req_valid_i capture write/addr/wdata; next cycle AR or AWW.
//  AR: arvalid_o=1, araddr_o=captured addr, held stable until arready_i; then R.
//  R: rready_o=1; on rvalid_i latch rdata_i, err|=(rid_i!=ID); then RESP.
//  AWW: awvalid_o and wvalid_o both asserted same cycle; each dropped independently after its own
//   ready sampled high (two done flags); AW and W ready in same cycle legal; both done -> B.
//  B: bready_o=1; on bvalid_i err|=(bid_i!=ID); then RESP.
//  RESP: resp_valid_o=1 with resp_write_o/resp_rdata_o/resp_err_o stable until resp_ready_i; then
//   IDLE. req_ready_o=0 in every state except IDLE (no request overlap).
//  Min latency, zero-wait slave: read accept->resp_valid 3 cycles; write 3 cycles.
//  Valid never deasserted before handshake; ready on R/B held until beat taken.
//  resp_rdata_o=0 for writes; captured addr bits below log2(DATA_W/8) driven as given (no masking).
//  Reset mid-transaction: state IDLE next edge, in-flight transaction dropped, no response issued.
// CONFIGURATION
//  AXI_MASTER_TIMEOUT_EN defined: counter clears on entering AR/AWW, increments in AR/R/AWW/B;
//   reaching TIMEOUT_CYC-1 without completion -> all AXI valids/readies drop, go RESP with
//   resp_err_o=1, resp_rdata_o=0. Late beats after abort are not accepted.
//  Not defined: no counter, FSM waits indefinitely; resp_err_o reflects id mismatch only.
// TESTING
//  write addr 0x1040 data {16{32'hA5A5_0001}}, slave ready -> one AW+W, B, resp_err=0, resp_write=1.
//  read addr 0x1040 after above -> araddr=0x1040, resp_rdata[511:0]=write data, resp_write=0.
//  AW ready 3 cycles before W ready -> awvalid drops after its handshake, wvalid held, one B only.
//  resp_ready_i low 5 cycles -> resp_valid and resp_rdata stable, req_ready_o=0 throughout.
//  rid_i=2 on read -> data still returned, resp_err_o=1; with TIMEOUT_EN and no rvalid for
//   TIMEOUT_CYC cycles -> resp_err_o=1, rdata=0, rready_o=0 after abort.
//  rst pulse while in AWW -> next cycle awvalid/wvalid=0, req_ready_o=1, no resp_valid.

Source files
------------

// File: rtl/axi_cache_master.sv
// axi_cache_master: single-outstanding AXI initiator for the DRAM-cache datapath.
// Accepts one line read (AR/R, 576b {tag,data}) or line write (AW/W/B, 512b)
// from the cache controller and returns one completion.
// Optional feature: define AXI_MASTER_TIMEOUT_EN to enable the TIMEOUT_CYC watchdog.
module axi_cache_master #(
  parameter int          ADDR_W      = 64,
  parameter int          DATA_W      = 512,
  parameter int          TAG_S       = 64,
  parameter int          ID_W        = 16,
  parameter int unsigned ID          = 1,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  // request from cache controller
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [DATA_W-1:0]       req_wdata_i,
  // completion to cache controller
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic                    resp_write_o,
  output logic [TAG_S+DATA_W-1:0] resp_rdata_o,
  output logic                    resp_err_o,
  // AXI read address / data
  output logic [ID_W-1:0]         arid_o,
  output logic [ADDR_W-1:0]       araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [ID_W-1:0]         rid_i,
  input  logic [TAG_S+DATA_W-1:0] rdata_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  // AXI write address / data / response
  output logic [ID_W-1:0]         awid_o,
  output logic [ADDR_W-1:0]       awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [ID_W-1:0]         wid_o,
  output logic [DATA_W-1:0]       wdata_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_W-1:0]         bid_i,
  input  logic                    bvalid_i,
  output logic                    bready_o
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_RESP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                aw_done;
  logic                w_done;

  // Fixed transaction id on every request channel.
  assign arid_o   = ID_W'(ID);
  assign awid_o   = ID_W'(ID);
  assign wid_o    = ID_W'(ID);
  assign araddr_o = addr_q;
  assign awaddr_o = addr_q;
  assign wdata_o  = wdata_q;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] tmo_cnt;
  logic             abort;

  // Abort when the watchdog expires and the pending beat did not arrive this cycle.
  always_comb begin
    abort = 1'b0;
    if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
      abort = (state == S_AR) || (state == S_AWW) ||
              (state == S_R && !rvalid_i) || (state == S_B && !bvalid_i);
    end
  end
`endif

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the line-sized address/data registers are reset too, so the AXI
      // address and data buses read 0 right after reset rather than X.
      state        <= S_IDLE;
      req_ready_o  <= 1'b1;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
      awvalid_o    <= 1'b0;
      wvalid_o     <= 1'b0;
      bready_o     <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_write_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so later assignments in this
      // block (the abort override) win cleanly and no ordering hazards arise.
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            req_ready_o  <= 1'b0;
            addr_q       <= req_addr_i;
            resp_write_o <= req_write_i;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            if (req_write_i) begin
              wdata_q   <= req_wdata_i;
              awvalid_o <= 1'b1;
              wvalid_o  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= S_AWW;
            end else begin
              arvalid_o <= 1'b1;
              state     <= S_AR;
            end
          end
        end
        S_AR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= S_R;
          end
        end
        S_R: begin
          if (rvalid_i) begin
            rready_o     <= 1'b0;
            resp_rdata_o <= rdata_i;
            resp_err_o   <= resp_err_o | (rid_i != ID_W'(ID));
            resp_valid_o <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_AWW: begin
          if (awready_i && !aw_done) begin
            awvalid_o <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (wready_i && !w_done) begin
            wvalid_o <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || awready_i) && (w_done || wready_i)) begin
            bready_o <= 1'b1;
            state    <= S_B;
          end
        end
        S_B: begin
          if (bvalid_i) begin
            bready_o     <= 1'b0;
            resp_err_o   <= resp_err_o | (bid_i != ID_W'(ID));
            resp_valid_o <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

`ifdef AXI_MASTER_TIMEOUT_EN
      if (state == S_IDLE) begin
        tmo_cnt <= '0;
      end else if (state != S_RESP) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (abort) begin
        arvalid_o    <= 1'b0;
        rready_o     <= 1'b0;
        awvalid_o    <= 1'b0;
        wvalid_o     <= 1'b0;
        bready_o     <= 1'b0;
        resp_rdata_o <= '0;
        resp_err_o   <= 1'b1;
        resp_valid_o <= 1'b1;
        state        <= S_RESP;
      end
`endif
    end
  end

endmodule
